// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, DIGIT bits per cycle, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a + ~b + 1 mode).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_n;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             accept, last, b_sub;
    logic [DIGIT:0]   slice;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_sub = sub;
`else
    assign b_sub = 1'b0;
`endif

    // Operands shift right each RUN cycle, so the active slice is always the low digit;
    // finished digits enter acc_q from the top and reach their final place after N shifts.
    always_comb begin
        accept = start && (state != RUN);
        last   = (cnt_q == CW'(N - 1));
        slice  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        acc_n  = (acc_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (accept) state_n = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = accept ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_q     <= a;
                b_q     <= b_sub ? ~b : b;
                carry_q <= b_sub ? 1'b1 : cin;
                cnt_q   <= '0;
            end else if (state == RUN) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                carry_q <= slice[DIGIT];
                cnt_q   <= cnt_q + 1'b1;
                acc_q   <= acc_n;
                if (last) begin
                    sum  <= acc_n;
                    cout <= slice[DIGIT];
                    // carry into the MSB recovered from its operand bits and sum bit
                    ovf  <= a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (DIGIT=1 and DIGIT=4 instances).
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in [2];
    logic [7:0] a_in     [2];
    logic [7:0] b_in     [2];
    logic       cin_in   [2];
    logic       sub_in   [2];
    logic       busy_o   [2];
    logic       done_o   [2];
    logic [7:0] sum_o    [2];
    logic       cout_o   [2];
    logic       ovf_o    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_in[0]), .a(a_in[0]), .b(b_in[0]), .cin(cin_in[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_in[0]),
`endif
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_in[1]), .a(a_in[1]), .b(b_in[1]), .cin(cin_in[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_in[1]),
`endif
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word integer arithmetic; overflow from the signed true result range.
    task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s,
                         output logic [7:0] es, output logic ec, output logic eo);
        int ub, sb, cc, tot, r;
        ub  = s ? int'(~bv) & 255 : int'(bv);
        cc  = s ? 1 : int'(c);
        sb  = s ? -int'($signed(bv)) : int'($signed(bv));
        tot = int'(av) + ub + cc;
        r   = int'($signed(av)) + sb + (s ? 0 : cc);
        es  = tot[7:0];
        ec  = tot[8];
        eo  = (r > 127) || (r < -128);
    endtask

    task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                          input logic c, input logic s, input string tag);
        logic [7:0] es, prev;
        logic       ec, eo;
        int         lat, n;
        n = (k == 0) ? 8 : 2;
        model(av, bv, c, s, es, ec, eo);
        a_in[k] = av; b_in[k] = bv; cin_in[k] = c; sub_in[k] = s; start_in[k] = 1'b1;
        prev = sum_o[k];
        @(posedge clk); #1;
        start_in[k] = 1'b0;
        check({tag, "_busy"}, 32'(busy_o[k]), 32'd1);
        check({tag, "_hidden"}, 32'(sum_o[k]), 32'(prev));
        lat = 0;
        while (!done_o[k] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(n));
        check({tag, "_sum"}, 32'(sum_o[k]), 32'(es));
        check({tag, "_cout"}, 32'(cout_o[k]), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf_o[k]), 32'(eo));
        check({tag, "_nbusy"}, 32'(busy_o[k]), 32'd0);
    endtask

    initial begin
        int saw, lat;
        logic s;
        for (int k = 0; k < 2; k++) begin
            start_in[k] = 0; a_in[k] = 0; b_in[k] = 0; cin_in[k] = 0; sub_in[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", 32'(busy_o[k]), 32'd0);
            check("rst_done", 32'(done_o[k]), 32'd0);
            check("rst_sum", 32'(sum_o[k]), 32'd0);
            check("rst_cout", 32'(cout_o[k]), 32'd0);
            check("rst_ovf", 32'(ovf_o[k]), 32'd0);
        end

        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "ff_01");
        check("ff_01_const", 32'({cout_o[0], sum_o[0]}), 32'h100);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "7f_01");
        check("7f_01_const", 32'({ovf_o[0], cout_o[0], sum_o[0]}), 32'h280);
        run_op(0, 8'h00, 8'h00, 1'b1, 1'b0, "cin_only");
        check("cin_only_const", 32'(sum_o[0]), 32'h01);
        @(posedge clk); #1;
        check("single_done", 32'(done_o[0]), 32'd0);

        // DIGIT=4: second start issued while first result is in DONE
        run_op(1, 8'h12, 8'h34, 1'b0, 1'b0, "d4_first");
        check("d4_const", 32'(sum_o[1]), 32'h46);
        run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, "d4_b2b");
        check("d4_b2b_const", 32'({cout_o[1], sum_o[1]}), 32'h100);

        // start during RUN must be ignored
        a_in[0] = 8'h21; b_in[0] = 8'h13; cin_in[0] = 0; sub_in[0] = 0; start_in[0] = 1;
        @(posedge clk); #1;
        start_in[0] = 0;
        @(posedge clk); #1;
        a_in[0] = 8'hEE; b_in[0] = 8'hEE; cin_in[0] = 1; start_in[0] = 1;
        @(posedge clk); #1;
        start_in[0] = 0;
        lat = 2; saw = 0;
        while (!done_o[0] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("run_ign_lat", 32'(lat), 32'd8);
        check("run_ign_sum", 32'(sum_o[0]), 32'h34);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done_o[0]) saw++;
        end
        check("run_ign_one_done", 32'(saw), 32'd0);

        // reset on the 3rd RUN cycle
        a_in[0] = 8'h0F; b_in[0] = 8'h0F; start_in[0] = 1;
        @(posedge clk); #1;
        start_in[0] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        check("abort_outs", 32'({done_o[0], ovf_o[0], cout_o[0], sum_o[0]}), 32'd0);
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_o[0]) saw++;
        end
        check("abort_no_done", 32'(saw), 32'd0);
        run_op(0, 8'h3C, 8'h4B, 1'b1, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, "sub_5_7");
        check("sub_5_7_const", 32'({ovf_o[0], cout_o[0], sum_o[0]}), 32'h0FE);
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, "sub_80_1");
        check("sub_80_1_const", 32'({ovf_o[0], sum_o[0]}), 32'h17F);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), s, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, minimum 2.
REQ-002 Parameter DIGIT, default 1: bits added per cycle; must divide WIDTH; N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; captures a, b, cin (and sub) when accepted.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in to the LSB digit.
REQ-009 sub  input  1  subtract mode; present only with SERIAL_ADDER_SUB_EN.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 done  output  1  one-cycle pulse; results valid.
REQ-012 sum  output  WIDTH  result, held until the next accepted start.
REQ-013 cout  output  1  carry out of the MSB.
REQ-014 ovf  output  1  signed overflow flag.

Function
REQ-015 The FSM shall have states IDLE, RUN and DONE.
REQ-016 start shall be accepted only in IDLE or DONE; an accepted start registers a, b, cin and sub, clears the digit counter and enters RUN.
REQ-017 start in RUN shall be ignored, with no effect on operands, counter or outputs.
REQ-018 Each RUN cycle shall add one DIGIT-bit slice, LSB first, using the registered carry from the previous slice (cin for slice 0).
REQ-019 On the edge that processes slice N-1, the FSM shall register sum, cout and ovf and enter DONE.
REQ-020 done shall be 1 exactly in DONE: N edges after the accepting edge, for one cycle.
REQ-021 DONE shall go to IDLE, or straight to RUN on a start accepted in DONE, so back-to-back operations take N+1 cycles each.
REQ-022 busy shall be 1 exactly in RUN.
REQ-023 sum and cout shall equal the low WIDTH bits and bit WIDTH of a + b + cin.
REQ-024 ovf shall be the carry into the MSB XOR cout.
REQ-025 sum, cout and ovf shall change only on entry to DONE, or on reset.
REQ-026 Intermediate partial sums shall not be visible on sum.

Reset
REQ-027 On rst=1 at a clock edge: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter and carry cleared.
REQ-028 rst shall take priority over start in the same cycle.
REQ-029 Reset during RUN shall abort the operation with no done pulse.

Configuration
REQ-030 Macro SERIAL_ADDER_SUB_EN defined: port sub exists; sub=1 computes a + ~b + 1, ignores cin, and cout=1 means no borrow; sub=0 behaves as plain add.
REQ-031 SERIAL_ADDER_SUB_EN undefined: no sub port, and the block adds only.

Verification (WIDTH=8 unless noted)
REQ-032 DIGIT=1, a=0xFF, b=0x01, cin=0 -> done 8 edges after start; sum=0x00, cout=1, ovf=0.
REQ-033 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x00, b=0x00, cin=1 -> sum=0x01.
REQ-034 DIGIT=4, a=0x12, b=0x34 -> done 2 edges after start; sum=0x46; a second start during DONE is accepted and completes 3 cycles after the first done.
REQ-035 start pulsed again during RUN with different operands -> first result unchanged, single done pulse.
REQ-036 rst asserted on the 3rd RUN cycle -> no done pulse, all outputs 0, a new start afterwards completes correctly.
REQ-037 SERIAL_ADDER_SUB_EN, sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, ovf=1.
